spi_peripheral: RTL and testbench



---
 rtl/spi_peripheral_if.sv | 20 ++
 rtl/spi_peripheral.sv | 163 ++++++++++++++++
 tb/tb_spi_peripheral.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - user-side TX holding register and RX word handshake
interface spi_peripheral_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_tx_byte;
  logic             i_tx_valid;
  logic             o_tx_ready;
  logic [WIDTH-1:0] o_rx_byte;
  logic             o_rx_valid;

  modport master (
    output i_tx_byte, i_tx_valid,
    input  o_tx_ready, o_rx_byte, o_rx_valid
  );

  modport slave (
    input  i_tx_byte, i_tx_valid,
    output o_tx_ready, o_rx_byte, o_rx_valid
  );
endinterface

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - mode 0 SPI responder, pins oversampled on i_clk
module spi_peripheral #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_sclk,
  input  logic                   i_cs,
  input  logic                   i_pico,
  output logic                   o_poci,
  output logic                   o_poci_oe,
  spi_peripheral_if.slave        user,
  output logic                   o_underrun,
  output logic                   o_abort,
  output logic                   o_busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, pico_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, pico_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [WIDTH-1:0]       hold_data, shift_tx, rx_byte;
  logic [WIDTH-2:0]       shift_rx;
  logic                   hold_full, word_done, rx_valid;
  logic [CW-1:0]          bit_cnt;
  logic                   do_load, do_shift, do_sample, go_idle, do_abort;
  logic                   tx_fire;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign pico_s    = pico_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign tx_fire   = user.i_tx_valid & ~hold_full;

  assign user.o_tx_ready = ~hold_full;
  assign user.o_rx_byte  = rx_byte;
  assign user.o_rx_valid = rx_valid;
  assign o_busy          = (state_q == ACTIVE);
  assign o_poci_oe       = (state_q == ACTIVE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      pico_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs};
      pico_sync <= {pico_sync[SYNC_STAGES-2:0], i_pico};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // CS deselect wins over any SCLK edge seen in the same cycle.
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_sample = 1'b0;
    go_idle   = 1'b0;
    do_abort  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          do_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d  = IDLE;
          go_idle  = 1'b1;
          do_abort = (bit_cnt != '0);
        end else begin
          do_sample = sclk_rise;
          if (sclk_fall) begin
            do_load  = word_done;
            do_shift = ~word_done;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_data  <= '0;
      hold_full  <= 1'b0;
      shift_tx   <= '0;
      shift_rx   <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      bit_cnt    <= '0;
      word_done  <= 1'b0;
      o_poci     <= 1'b0;
      o_underrun <= 1'b0;
      o_abort    <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      o_underrun <= 1'b0;
      o_abort    <= do_abort;

      // A write lands only while hold is empty, so it never races a hold->shift load.
      if (tx_fire) begin
        hold_data <= user.i_tx_byte;
        hold_full <= 1'b1;
      end

      if (do_load) begin
        word_done <= 1'b0;
        if (hold_full) begin
          shift_tx  <= hold_data;
          o_poci    <= hold_data[WIDTH-1];
          hold_full <= 1'b0;
        end else begin
          shift_tx   <= '0;
          o_poci     <= 1'b0;
          o_underrun <= 1'b1;
        end
      end

      if (do_shift) begin
        shift_tx <= shift_tx << 1;
        o_poci   <= shift_tx[WIDTH-2];
      end

      if (do_sample) begin
        if (bit_cnt == CW'(WIDTH - 1)) begin
          rx_byte   <= {shift_rx, pico_s};
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
        shift_rx <= {shift_rx[WIDTH-3:0], pico_s};
      end

      if (go_idle) begin
        bit_cnt   <= '0;
        word_done <= 1'b0;
        o_poci    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - bench driving the SPI pins as a mode 0 controller
module tb_spi_peripheral;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic pico = 1'b0;
  logic poci, poci_oe, underrun, abort_p, busy;

  spi_peripheral_if #(.WIDTH(W)) uif ();

  spi_peripheral #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sclk     (sclk),
    .i_cs       (cs),
    .i_pico     (pico),
    .o_poci     (poci),
    .o_poci_oe  (poci_oe),
    .user       (uif.slave),
    .o_underrun (underrun),
    .o_abort    (abort_p),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_rx, n_ur, n_ab;
  logic [7:0] rx_q[$];

  logic [7:0] txw[0:3];
  logic [7:0] mosi[0:3];
  logic [7:0] got[0:3];
  bit         prov[0:3];

  always @(negedge clk) begin
    if (rst_n) begin
      if (uif.o_rx_valid) begin
        rx_q.push_back(uif.o_rx_byte);
        n_rx++;
      end
      if (underrun) n_ur++;
      if (abort_p) n_ab++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_hold(input logic [7:0] b);
    chk("tx_ready_before_write", 32'(uif.o_tx_ready), 32'd1);
    uif.i_tx_byte  = b;
    uif.i_tx_valid = 1'b1;
    wait_clks(1);
    uif.i_tx_valid = 1'b0;
  endtask

  // Reference: every load (CS fall, and the fall after each completed word)
  // takes the provided byte or zero; loads with nothing provided underrun.
  task automatic run_frame(input string name, input int nw, input int ab_rises, input bit sim_wr);
    int  loads, exp_ur, done_words;
    bit  stop, due;
    logic [7:0] exp_poci;
    n_rx = 0; n_ur = 0; n_ab = 0;
    rx_q.delete();
    if (prov[0] && !sim_wr) write_hold(txw[0]);
    wait_clks(3);
    cs = 1'b0;
    if (sim_wr) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      uif.i_tx_byte  = txw[1];
      uif.i_tx_valid = 1'b1;
      wait_clks(1);
      uif.i_tx_valid = 1'b0;
      wait_clks(6);
    end else begin
      wait_clks(8);
    end
    stop = 1'b0;
    done_words = 0;
    for (int k = 0; k < nw && !stop; k++) begin
      for (int i = 0; i < 8 && !stop; i++) begin
        pico = mosi[k][7-i];
        wait_clks(8);
        sclk = 1'b1;
        got[k][7-i] = poci;
        if (k == 0 && i == 0) begin
          chk({name, "/busy"}, 32'(busy), 32'd1);
          chk({name, "/poci_oe"}, 32'(poci_oe), 32'd1);
          chk({name, "/tx_ready_after_load"}, 32'(uif.o_tx_ready), sim_wr ? 32'd0 : 32'd1);
        end
        if (ab_rises > 0 && k == nw - 1 && i + 1 == ab_rises) stop = 1'b1;
        due = (k + 1 <= 3) && prov[k+1] && !(sim_wr && k == 0) && (k + 1 < nw || ab_rises == 0);
        if (!stop && i == 3 && due) begin
          write_hold(txw[k+1]);
          wait_clks(7);
        end else begin
          wait_clks(8);
        end
        sclk = 1'b0;
      end
      if (!stop) done_words++;
    end
    wait_clks(8);
    cs = 1'b1;
    wait_clks(12);

    loads  = (ab_rises > 0) ? nw : nw + 1;
    exp_ur = 0;
    for (int l = 0; l < loads; l++) if (!prov[l]) exp_ur++;
    for (int k = 0; k < done_words; k++) begin
      exp_poci = prov[k] ? txw[k] : 8'h00;
      chk($sformatf("%s/poci_word%0d", name, k), 32'(got[k]), 32'(exp_poci));
      chk($sformatf("%s/rx_word%0d", name, k), (rx_q.size() > k) ? 32'(rx_q[k]) : 'x, 32'(mosi[k]));
    end
    if (done_words > 0)
      chk({name, "/rx_byte_held"}, 32'(uif.o_rx_byte), 32'(mosi[done_words-1]));
    chk({name, "/rx_valid_count"}, n_rx, done_words);
    chk({name, "/underrun_count"}, n_ur, exp_ur);
    chk({name, "/abort_count"}, n_ab, (ab_rises > 0) ? 1 : 0);
    chk({name, "/tx_ready_end"}, 32'(uif.o_tx_ready), 32'd1);
    chk({name, "/busy_end"}, 32'(busy), 32'd0);
    chk({name, "/poci_oe_end"}, 32'(poci_oe), 32'd0);
    chk({name, "/poci_end"}, 32'(poci), 32'd0);
  endtask

  task automatic set_words(input logic [7:0] t0, t1, t2, input bit p0, p1, p2,
                           input logic [7:0] m0, m1);
    txw[0] = t0; txw[1] = t1; txw[2] = t2; txw[3] = 8'h00;
    prov[0] = p0; prov[1] = p1; prov[2] = p2; prov[3] = 1'b0;
    mosi[0] = m0; mosi[1] = m1; mosi[2] = 8'h00; mosi[3] = 8'h00;
  endtask

  initial begin
    uif.i_tx_byte  = '0;
    uif.i_tx_valid = 1'b0;
    wait_clks(3);
    chk("reset/poci", 32'(poci), 32'd0);
    chk("reset/poci_oe", 32'(poci_oe), 32'd0);
    chk("reset/tx_ready", 32'(uif.o_tx_ready), 32'd1);
    chk("reset/rx_byte", 32'(uif.o_rx_byte), 32'd0);
    chk("reset/pulses", {29'd0, uif.o_rx_valid, underrun, abort_p}, 32'd0);
    chk("reset/busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clks(2);

    set_words(8'hA5, 8'h00, 8'h00, 1, 0, 0, 8'h3C, 8'h00);
    run_frame("single", 1, 0, 0);

    set_words(8'h11, 8'h22, 8'hEE, 1, 1, 1, 8'h81, 8'h7E);
    run_frame("b2b", 2, 0, 0);

    set_words(8'h00, 8'h5E, 8'h00, 0, 1, 0, 8'hFF, 8'h00);
    run_frame("underrun", 1, 0, 0);

    set_words(8'h5A, 8'h00, 8'h00, 1, 0, 0, 8'hB7, 8'h00);
    run_frame("abort", 1, 5, 0);
    set_words(8'hC3, 8'h00, 8'h00, 1, 0, 0, 8'h99, 8'h00);
    run_frame("after_abort", 1, 0, 0);

    set_words(8'h00, 8'h44, 8'h3D, 0, 1, 1, 8'h12, 8'hE4);
    run_frame("simul_wr", 2, 0, 1);

    // Reset asserted asynchronously in the middle of a frame.
    write_hold(8'h77);
    cs = 1'b0;
    wait_clks(8);
    pico = 1'b1;
    sclk = 1'b1;
    wait_clks(4);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset/poci", 32'(poci), 32'd0);
    chk("midreset/poci_oe", 32'(poci_oe), 32'd0);
    chk("midreset/tx_ready", 32'(uif.o_tx_ready), 32'd1);
    chk("midreset/rx_byte", 32'(uif.o_rx_byte), 32'd0);
    chk("midreset/pulses", {29'd0, uif.o_rx_valid, underrun, abort_p}, 32'd0);
    chk("midreset/busy", 32'(busy), 32'd0);
    sclk = 1'b0;
    cs   = 1'b1;
    pico = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    chk("midreset/hold_empty", 32'(uif.o_tx_ready), 32'd1);

    for (int r = 0; r < 20; r++) begin
      int nw, ab;
      nw = $urandom_range(1, 3);
      for (int l = 0; l < 4; l++) begin
        prov[l] = 1'($urandom_range(0, 1));
        txw[l]  = 8'($urandom);
        mosi[l] = 8'($urandom);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame($sformatf("rand%0d", r), nw, ab, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
